pc_ir_unit: RTL

//  Program-counter / instruction-register stage of the multicycle CPU.
//  - Executes the controller's PC and IR strobes: fetch latch, PC update, branch resolution.
//  - Supplies the controller's opcode and the decoded instruction fields to the register file and immediate logic.
//  - Holds the ALUOut and MDR holding registers and a retired-instruction counter.

---
 rtl/pc_ir_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pc_ir_unit.sv
// pc_ir_unit -- program-counter / instruction-register stage of the multicycle CPU.
//
// Acts on the controller's PC and IR strobes. It latches the fetched instruction,
// updates the PC and resolves branches. It presents the opcode and the decoded
// instruction fields, and holds the ALUOut and MDR registers. It also counts
// retired instructions, one per IR load.
//
// Ports
//   Clk, Reset                 clock, synchronous active-high reset
//   IRWrite                    load IR from imem_rdata this edge
//   PCWrite, PCWriteCond       unconditional / branch-conditional PC load
//   BranchCond[1:0]            00 EQ, 01 NE, 10 LT, 11 LE
//   PCSource[1:0]              00 alu_result, 01 alu_out, 10 jump target, 11 hold
//   alu_result, alu_zero, alu_neg   combinational ALU result and flags
//   imem_rdata, dmem_rdata     instruction word at imem_addr, data memory word
//   imem_addr, pc              current PC
//   opcode, rs, rt, rd, imm16  combinational slices of IR
//   alu_out, mdr               ALUOut and memory data registers
//   branch_taken               PCWriteCond & branch condition true
//   instr_count                IR loads since reset, wrapping
module pc_ir_unit #(
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IRWrite,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic [1:0]        BranchCond,
  input  logic [1:0]        PCSource,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] imem_addr,
  output logic [DATA_W-1:0] pc,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] mdr,
  output logic              branch_taken,
  output logic [DATA_W-1:0] instr_count
);

  localparam logic [1:0] BC_EQ = 2'b00;
  localparam logic [1:0] BC_NE = 2'b01;
  localparam logic [1:0] BC_LT = 2'b10;
  localparam logic [1:0] BC_LE = 2'b11;

  localparam logic [1:0] PCS_ALU_RESULT = 2'b00;
  localparam logic [1:0] PCS_ALU_OUT    = 2'b01;
  localparam logic [1:0] PCS_JUMP       = 2'b10;
  localparam logic [1:0] PCS_HOLD       = 2'b11;

  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_alu_out;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_instr_count;

  logic              w_cond_true;
  logic              w_pc_load;
  logic [DATA_W-1:0] w_pc_next;
  logic [DATA_W-1:0] w_jump_target;

  // Branch condition from the ALU flags of the compare (A-B).
  always_comb begin
    w_cond_true = 1'b0;
    case (BranchCond)
      BC_EQ:   w_cond_true = alu_zero;
      BC_NE:   w_cond_true = ~alu_zero;
      BC_LT:   w_cond_true = alu_neg;
      BC_LE:   w_cond_true = alu_neg | alu_zero;
      default: w_cond_true = 1'b0;
    endcase
  end

  // The jump keeps the PC's top bits and replaces the low 26 with the IR target field.
  assign w_jump_target = {r_pc[DATA_W-1:26], r_ir[25:0]};

  always_comb begin
    w_pc_next = r_pc;
    case (PCSource)
      PCS_ALU_RESULT: w_pc_next = alu_result;
      PCS_ALU_OUT:    w_pc_next = r_alu_out;
      PCS_JUMP:       w_pc_next = w_jump_target;
      PCS_HOLD:       w_pc_next = r_pc;
      default:        w_pc_next = r_pc;
    endcase
  end

  // PCWrite alone is enough to load, so it wins over a false branch condition.
  assign w_pc_load    = PCWrite | (PCWriteCond & w_cond_true);
  assign branch_taken = PCWriteCond & w_cond_true;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc <= RESET_PC;
    end else if (w_pc_load) begin
      r_pc <= w_pc_next;
    end
  end

  // imem_rdata is addressed by the current (pre-update) PC, so a fetch that
  // also advances the PC still captures the word at the old address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ir          <= '0;
      r_instr_count <= '0;
    end else if (IRWrite) begin
      r_ir          <= imem_rdata;
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_alu_out <= '0;
      r_mdr     <= '0;
    end else begin
      r_alu_out <= alu_result;
      r_mdr     <= dmem_rdata;
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign opcode      = r_ir[31:26];
  assign rs          = r_ir[25:21];
  assign rt          = r_ir[20:16];
  assign rd          = r_ir[15:11];
  assign imm16       = r_ir[15:0];
  assign alu_out     = r_alu_out;
  assign mdr         = r_mdr;
  assign instr_count = r_instr_count;

endmodule
